// File: rtl/cal_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : cal_pkg                                                |
// | Description : Shared datapath width, control-flow opcode constants   |
// |               and the control-class test used by the fetch stage.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cal_pkg;

   localparam int XLEN = 32;

   localparam logic [5:0] OP_BEZ = 6'b101000;
   localparam logic [5:0] OP_BNE = 6'b101001;
   localparam logic [5:0] OP_JMP = 6'b101010;

   // All branch/jump opcodes share this 3-bit prefix
   localparam logic [2:0] CTRL_CLASS = 3'b101;

   localparam logic [XLEN-1:0] NOP_WORD = 32'h0;

   function automatic logic is_ctrl_word(input logic [XLEN-1:0] word);
      return (word[XLEN-1:XLEN-3] == CTRL_CLASS);
   endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_unit_if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_id_reg                                              |
// | Description : IF/ID pipeline register. Flush clears valid and the    |
// |               control flag while the other fields hold; load         |
// |               captures a fetched word; otherwise everything holds.   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module if_id_reg
   import cal_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_flush,
   input  logic [XLEN-1:0] i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic [XLEN-1:0] i_pc_plus1,
   output logic            o_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_pc_plus1,
   output logic            o_is_ctrl
);

   logic            r_valid;
   logic [XLEN-1:0] r_instr;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_pc_plus1;
   logic            r_is_ctrl;

   // Pipeline register: flush has priority over load, default is hold
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_instr    <= NOP_WORD;
         r_pc       <= '0;
         r_pc_plus1 <= '0;
         r_is_ctrl  <= 1'b0;
      end else if (i_flush) begin
         r_valid    <= 1'b0;
         r_is_ctrl  <= 1'b0;
      end else if (i_load) begin
         r_valid    <= 1'b1;
         r_instr    <= i_instr;
         r_pc       <= i_pc;
         r_pc_plus1 <= i_pc_plus1;
         r_is_ctrl  <= is_ctrl_word(i_instr);
      end
   end

   assign o_valid    = r_valid;
   assign o_instr    = r_instr;
   assign o_pc       = r_pc;
   assign o_pc_plus1 = r_pc_plus1;
   assign o_is_ctrl  = r_is_ctrl;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : instruction_fetch_unit                                 |
// | Description : Fetch stage. Holds the PC, selects sequential /        |
// |               redirect / hold next PC with wrap at IMEM_DEPTH, and   |
// |               registers the fetched word into IF/ID.                 |
// |               Optional macro FETCH_PERF_CNT_EN adds fetch_count and  |
// |               stall_count performance counters.                      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module instruction_fetch_unit
   import cal_pkg::*;
#(
   parameter int IMEM_DEPTH = 100,
   parameter int RESET_PC   = 0
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_instr,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_target,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_instr,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus1,
   output logic            if_id_is_ctrl,
`ifdef FETCH_PERF_CNT_EN
   output logic [XLEN-1:0] fetch_count,
   output logic [XLEN-1:0] stall_count,
`endif
   output logic            addr_err
);

   localparam logic [XLEN-1:0] c_depth    = XLEN'(IMEM_DEPTH);
   localparam logic [XLEN-1:0] c_last_pc  = XLEN'(IMEM_DEPTH - 1);
   localparam logic [XLEN-1:0] c_reset_pc = XLEN'(RESET_PC);

   logic [XLEN-1:0] r_pc;
   logic            r_addr_err;
   logic [XLEN-1:0] w_pc_plus1;
   logic            w_target_ok;
   logic            w_advance;

   // Sequential successor wraps at the last memory word; unsigned range check on target
   assign w_pc_plus1  = (r_pc == c_last_pc) ? '0 : r_pc + 32'd1;
   assign w_target_ok = (redirect_target < c_depth);
   assign w_advance   = !redirect_valid && !stall;

   // PC register: redirect beats stall, stall beats sequential advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc <= c_reset_pc;
      end else if (redirect_valid) begin
         r_pc <= w_target_ok ? redirect_target : '0;
      end else if (!stall) begin
         r_pc <= w_pc_plus1;
      end
   end

   // Sticky out-of-range redirect flag, cleared only by reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr_err <= 1'b0;
      end else if (redirect_valid && !w_target_ok) begin
         r_addr_err <= 1'b1;
      end
   end

   if_id_reg u_if_id_reg (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_advance),
      .i_flush    (redirect_valid),
      .i_instr    (imem_instr),
      .i_pc       (r_pc),
      .i_pc_plus1 (w_pc_plus1),
      .o_valid    (if_id_valid),
      .o_instr    (if_id_instr),
      .o_pc       (if_id_pc),
      .o_pc_plus1 (if_id_pc_plus1),
      .o_is_ctrl  (if_id_is_ctrl)
   );

`ifdef FETCH_PERF_CNT_EN
   logic [XLEN-1:0] r_fetch_count;
   logic [XLEN-1:0] r_stall_count;

   // Free-running wrap-around counters of advances and stalled edges
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_count <= '0;
         r_stall_count <= '0;
      end else begin
         if (w_advance) begin
            r_fetch_count <= r_fetch_count + 32'd1;
         end
         if (stall && !redirect_valid) begin
            r_stall_count <= r_stall_count + 32'd1;
         end
      end
   end

   assign fetch_count = r_fetch_count;
   assign stall_count = r_stall_count;
`endif

   assign imem_addr = r_pc;
   assign addr_err  = r_addr_err;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_instruction_fetch_unit                              |
// | Description : Directed scoreboard bench for instruction_fetch_unit.  |
// |               Honours FETCH_PERF_CNT_EN for the counter ports.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_instruction_fetch_unit;

   localparam int DEPTH = 100;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc_plus1;
      logic        is_ctrl;
   } ent_t;

   logic        clk;
   logic        rst;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pc_plus1;
   logic        if_id_is_ctrl;
   logic        addr_err;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   logic [31:0] mem [0:DEPTH-1];

   int   checks;
   int   errors;
   ent_t sb_q[$];
   ent_t m_last;
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_err;
   logic [31:0] m_fetch;
   logic [31:0] m_stall;

   instruction_fetch_unit #(.IMEM_DEPTH(DEPTH), .RESET_PC(0)) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_addr       (imem_addr),
      .imem_instr      (imem_instr),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .if_id_valid     (if_id_valid),
      .if_id_instr     (if_id_instr),
      .if_id_pc        (if_id_pc),
      .if_id_pc_plus1  (if_id_pc_plus1),
      .if_id_is_ctrl   (if_id_is_ctrl),
`ifdef FETCH_PERF_CNT_EN
      .fetch_count     (fetch_count),
      .stall_count     (stall_count),
`endif
      .addr_err        (addr_err)
   );

   // Combinational instruction memory
   assign imem_instr = (imem_addr < 32'(DEPTH)) ? mem[imem_addr[6:0]] : 32'h0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mplus1(input logic [31:0] p);
      return (p == 32'(DEPTH - 1)) ? 32'd0 : p + 32'd1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare every DUT output against the model state
   task automatic check_all(input string tag);
      chk({tag, ".imem_addr"}, imem_addr, m_pc);
      chk({tag, ".valid"}, 32'(if_id_valid), 32'(m_valid));
      chk({tag, ".instr"}, if_id_instr, m_last.instr);
      chk({tag, ".pc"}, if_id_pc, m_last.pc);
      chk({tag, ".pc_plus1"}, if_id_pc_plus1, m_last.pc_plus1);
      chk({tag, ".is_ctrl"}, 32'(if_id_is_ctrl), 32'(m_last.is_ctrl));
      chk({tag, ".addr_err"}, 32'(addr_err), 32'(m_err));
`ifdef FETCH_PERF_CNT_EN
      chk({tag, ".fetch_count"}, fetch_count, m_fetch);
      chk({tag, ".stall_count"}, stall_count, m_stall);
`endif
   endtask

   // One clock edge: drive inputs, predict, then pop and compare after the edge
   task automatic cycle(input string tag, input logic s, input logic r, input logic [31:0] t);
      ent_t e;
      stall           = s;
      redirect_valid  = r;
      redirect_target = t;
      if (r) begin
         m_valid        = 1'b0;
         m_last.is_ctrl = 1'b0;
         if (t >= 32'(DEPTH)) begin
            m_err = 1'b1;
            m_pc  = 32'd0;
         end else begin
            m_pc = t;
         end
      end else if (s) begin
         m_stall = m_stall + 32'd1;
      end else begin
         e.instr    = mem[m_pc[6:0]];
         e.pc       = m_pc;
         e.pc_plus1 = mplus1(m_pc);
         e.is_ctrl  = (e.instr[31:29] == 3'b101);
         sb_q.push_back(e);
         m_pc    = mplus1(m_pc);
         m_valid = 1'b1;
         m_fetch = m_fetch + 32'd1;
      end
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
         m_last = sb_q.pop_front();
      end
      check_all(tag);
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_last  = '0;
      m_pc    = 32'd0;
      m_valid = 1'b0;
      m_err   = 1'b0;
      m_fetch = 32'd0;
      m_stall = 32'd0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((k % 4) == 1) mem[k] = {3'b101, 3'(k % 3), 26'(k)};
         else              mem[k] = 32'h1000_0000 + 32'(k * 7);
      end
      model_reset();
      rst             = 1'b1;
      stall           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset");
      rst = 1'b0;

      // Sequential fetch from reset up to PC=4
      for (int i = 0; i < 4; i++) cycle("seq", 1'b0, 1'b0, 32'd0);
      // Three stalled edges holding PC=4 and mem[3]
      for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0, 32'd0);
      cycle("post_stall", 1'b0, 1'b0, 32'd0);
      cycle("seq6", 1'b0, 1'b0, 32'd0);
      // Redirect at PC=6 to 16
      cycle("redir16", 1'b0, 1'b1, 32'd16);
      cycle("after16", 1'b0, 1'b0, 32'd0);
      cycle("seq17", 1'b0, 1'b0, 32'd0);
      // Redirect together with stall
      cycle("redir_stall", 1'b1, 1'b1, 32'd40);
      cycle("stall_after_flush", 1'b1, 1'b0, 32'd0);
      cycle("after40", 1'b0, 1'b0, 32'd0);
      // Back-to-back redirects
      cycle("b2b_a", 1'b0, 1'b1, 32'd60);
      cycle("b2b_b", 1'b0, 1'b1, 32'd97);
      // Run through the wrap at 99
      for (int i = 0; i < 5; i++) cycle("wrap", 1'b0, 1'b0, 32'd0);
      // Out-of-range redirect sets the sticky error
      cycle("redir150", 1'b0, 1'b1, 32'd150);
      cycle("err_sticky", 1'b0, 1'b0, 32'd0);
      cycle("redir_ok", 1'b0, 1'b1, 32'd8);
      cycle("err_still", 1'b0, 1'b0, 32'd0);

      // Asynchronous reset pulsed mid-cycle during a redirect
      redirect_valid  = 1'b1;
      redirect_target = 32'd30;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      redirect_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all("rst_hold");
      for (int i = 0; i < 3; i++) cycle("seq_after_rst", 1'b0, 1'b0, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #20000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
